// File: rtl/sobel_pkg.sv
// Shared definitions for sobel_grad_pipe: kernel mode codes, per-mode tap weights
// and the unsigned saturating clamp used by the output stage.
package sobel_pkg;

    localparam logic [1:0] KSEL_SOBEL   = 2'd0;
    localparam logic [1:0] KSEL_PREWITT = 2'd1;
    localparam logic [1:0] KSEL_SCHARR  = 2'd2;

    typedef struct packed {
        logic [3:0] outer;
        logic [3:0] centre;
    } weights_t;

    // Code 3 is reserved and behaves as Sobel.
    function automatic logic [1:0] norm_mode(input logic [1:0] ksel);
        return (ksel == 2'd3) ? KSEL_SOBEL : ksel;
    endfunction

    function automatic weights_t kernel_weights(input logic [1:0] mode);
        weights_t wt;
        case (mode)
            KSEL_PREWITT: wt = '{outer: 4'd1, centre: 4'd1};
            KSEL_SCHARR:  wt = '{outer: 4'd3, centre: 4'd10};
            default:      wt = '{outer: 4'd1, centre: 4'd2};
        endcase
        return wt;
    endfunction

    // Clamp v to the unsigned range of a w-bit field; callers keep the low w bits.
    function automatic logic [31:0] sat_clamp(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/sobel_grad_pipe_tap3_sum.sv
// sobel_tap3_sum: combinational weighted sum outer*a + centre*m + outer*b for one
// kernel side; DATA_WIDTH+4 bits holds the largest (Scharr, 16x) sum.
module sobel_tap3_sum
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)(
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] tap_a,
    input  logic [DATA_WIDTH-1:0] tap_m,
    input  logic [DATA_WIDTH-1:0] tap_b,
    output logic [DATA_WIDTH+3:0] sum
);
    localparam int SW = DATA_WIDTH + 4;

    weights_t wt;

    assign wt  = kernel_weights(mode);
    assign sum = SW'(wt.outer)  * SW'(tap_a)
               + SW'(wt.centre) * SW'(tap_m)
               + SW'(wt.outer)  * SW'(tap_b);

endmodule

// File: rtl/sobel_grad_pipe.sv
// sobel_grad_pipe: 3-stage 3x3 gradient engine (Sobel/Prewitt/Scharr) with valid/ready
// backpressure. Define SOBEL_THRESH_EN to add the threshold input and out_edge flag.
module sobel_grad_pipe
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 12
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              kernel_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] in_data,
    input  logic                    in_user,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_gx,
    output logic [OUT_WIDTH-1:0]    out_gy,
    output logic [OUT_WIDTH-1:0]    out_mag,
    output logic                    out_user,
    output logic                    out_last
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [OUT_WIDTH-1:0]    threshold,
    output logic                    out_edge
`endif
);
    localparam int SW     = DATA_WIDTH + 4;
    localparam int STAGES = 3;

    if (OUT_WIDTH < DATA_WIDTH + 2 || OUT_WIDTH > 30 || SW > 31) begin : g_bad_width
        $error("sobel_grad_pipe: OUT_WIDTH must be >= DATA_WIDTH+2 (and fit the 32-bit clamp)");
    end

    typedef struct packed {
        logic [SW-1:0] px, nx, py, ny;
        logic          user, last;
`ifdef SOBEL_THRESH_EN
        logic [OUT_WIDTH-1:0] thr;
`endif
    } s1_t;

    typedef struct packed {
        logic [SW-1:0] dx, dy;
        logic          user, last;
`ifdef SOBEL_THRESH_EN
        logic [OUT_WIDTH-1:0] thr;
`endif
    } s2_t;

    function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic                                 en;
    logic                                 frame_start;
    logic [STAGES:1]                      vld_q;
    logic [STAGES:0]                      vld_pipe;
    logic [1:0]                           mode_q, mode_eff;
    logic [2:0][2:0][DATA_WIDTH-1:0]      pix;   // [row][col]
    logic [3:0][2:0][DATA_WIDTH-1:0]      taps;  // sides: px, nx, py, ny
    logic [3:0][SW-1:0]                   sums;
    s1_t                                  s1_d, s1_q;
    s2_t                                  s2_d, s2_q;
    logic [OUT_WIDTH-1:0]                 gx_sat, gy_sat, mag_sat;
    logic [OUT_WIDTH:0]                   mag_sum;
    logic [31:0]                          gx_c, gy_c, mag_c;
`ifdef SOBEL_THRESH_EN
    logic [OUT_WIDTH-1:0]                 thr_q;
`endif

    assign vld_pipe    = {vld_q, in_valid};
    assign out_valid   = vld_q[STAGES];
    assign en          = !out_valid || out_ready;
    assign in_ready    = en;
    assign frame_start = in_valid && in_user;
    // A frame-start beat already computes with the mode it carries.
    assign mode_eff    = frame_start ? norm_mode(kernel_sel) : mode_q;

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign pix[r][c] = in_data[(8 - (3*c + r))*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_taps
        assign taps[0][i] = pix[i][2];
        assign taps[1][i] = pix[i][0];
        assign taps[2][i] = pix[2][i];
        assign taps[3][i] = pix[0][i];
    end

    for (genvar s = 0; s < 4; s++) begin : g_side
        sobel_tap3_sum #(.DATA_WIDTH(DATA_WIDTH)) u_sum (
            .mode  (mode_eff),
            .tap_a (taps[s][0]),
            .tap_m (taps[s][1]),
            .tap_b (taps[s][2]),
            .sum   (sums[s])
        );
    end

    always_comb begin
        s1_d      = '0;
        s1_d.px   = sums[0];
        s1_d.nx   = sums[1];
        s1_d.py   = sums[2];
        s1_d.ny   = sums[3];
        s1_d.user = in_user;
        s1_d.last = in_last;
`ifdef SOBEL_THRESH_EN
        s1_d.thr  = frame_start ? threshold : thr_q;
`endif
    end

    always_comb begin
        s2_d      = '0;
        s2_d.dx   = abs_diff(s1_q.px, s1_q.nx);
        s2_d.dy   = abs_diff(s1_q.py, s1_q.ny);
        s2_d.user = s1_q.user;
        s2_d.last = s1_q.last;
`ifdef SOBEL_THRESH_EN
        s2_d.thr  = s1_q.thr;
`endif
    end

    // Summing the already-clamped parts gives the same clamped magnitude.
    always_comb begin
        gx_c    = sat_clamp(32'(s2_q.dx), OUT_WIDTH);
        gy_c    = sat_clamp(32'(s2_q.dy), OUT_WIDTH);
        gx_sat  = gx_c[OUT_WIDTH-1:0];
        gy_sat  = gy_c[OUT_WIDTH-1:0];
        mag_sum = {1'b0, gx_sat} + {1'b0, gy_sat};
        mag_c   = sat_clamp(32'(mag_sum), OUT_WIDTH);
        mag_sat = mag_c[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            mode_q   <= KSEL_SOBEL;
            s1_q     <= '0;
            s2_q     <= '0;
            out_gx   <= '0;
            out_gy   <= '0;
            out_mag  <= '0;
            out_user <= 1'b0;
            out_last <= 1'b0;
`ifdef SOBEL_THRESH_EN
            thr_q    <= '1;
            out_edge <= 1'b0;
`endif
        end else if (en) begin
            vld_q    <= vld_pipe[STAGES-1:0];
            if (frame_start) mode_q <= norm_mode(kernel_sel);
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            out_gx   <= gx_sat;
            out_gy   <= gy_sat;
            out_mag  <= mag_sat;
            out_user <= s2_q.user;
            out_last <= s2_q.last;
`ifdef SOBEL_THRESH_EN
            if (frame_start) thr_q <= threshold;
            out_edge <= (mag_sat > s2_q.thr);
`endif
        end
    end

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Directed scoreboard bench for sobel_grad_pipe; SOBEL_THRESH_EN enables the edge checks.
module tb_sobel_grad_pipe;
    localparam int DW   = 8;
    localparam int OW   = 12;
    localparam int MAXV = (1 << OW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      kernel_sel;
    logic            in_valid, in_ready, in_user, in_last;
    logic [9*DW-1:0] in_data;
    logic            out_valid, out_ready, out_user, out_last;
    logic [OW-1:0]   out_gx, out_gy, out_mag;
`ifdef SOBEL_THRESH_EN
    logic [OW-1:0]   threshold;
    logic            out_edge;
`endif

    always #5 clk = ~clk;

    sobel_grad_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .kernel_sel(kernel_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_user(in_user), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag),
        .out_user(out_user), .out_last(out_last)
`ifdef SOBEL_THRESH_EN
        , .threshold(threshold), .out_edge(out_edge)
`endif
    );

    typedef struct {
        int   gx, gy, mag;
        logic user, last, edg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tb_mode = 0;
    int   tb_thr  = MAXV;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int px(input logic [9*DW-1:0] w, input int r, input int c);
        return int'(w[(8-(3*c+r))*DW +: DW]);
    endfunction

    function automatic logic [9*DW-1:0] setp(input logic [9*DW-1:0] w, input int r, input int c, input int v);
        logic [9*DW-1:0] t;
        t = w;
        t[(8-(3*c+r))*DW +: DW] = DW'(v);
        return t;
    endfunction

    function automatic logic [9*DW-1:0] cols(input int l, input int m, input int rr);
        logic [9*DW-1:0] t;
        t = '0;
        for (int r = 0; r < 3; r++) begin
            t = setp(t, r, 0, l);
            t = setp(t, r, 1, m);
            t = setp(t, r, 2, rr);
        end
        return t;
    endfunction

    // Direct signed convolution, then |.| and clamping.
    function automatic exp_t model(input logic [9*DW-1:0] w, input int mode, input int thr,
                                   input logic u, input logic l);
        int   o, c, gx, gy, m;
        int   wt[3];
        exp_t e;
        case (mode)
            1:       begin o = 1; c = 1;  end
            2:       begin o = 3; c = 10; end
            default: begin o = 1; c = 2;  end
        endcase
        wt[0] = o; wt[1] = c; wt[2] = o;
        gx = 0; gy = 0;
        for (int k = 0; k < 3; k++) begin
            gx += wt[k] * (px(w, k, 2) - px(w, k, 0));
            gy += wt[k] * (px(w, 2, k) - px(w, 0, k));
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m     = gx + gy;
        e.gx  = (gx > MAXV) ? MAXV : gx;
        e.gy  = (gy > MAXV) ? MAXV : gy;
        e.mag = (m  > MAXV) ? MAXV : m;
        e.user = u;
        e.last = l;
        e.edg  = (e.mag > thr);
        return e;
    endfunction

    task automatic accept_push(input logic [9*DW-1:0] w, input logic u, input logic l,
                               input logic [1:0] ks, input int thr);
        if (u) begin
            tb_mode = (ks == 2'd3) ? 0 : int'(ks);
            tb_thr  = thr;
        end
        sb.push_back(model(w, tb_mode, tb_thr, u, l));
    endtask

    task automatic drive(input logic [9*DW-1:0] w, input logic u, input logic l,
                         input logic [1:0] ks, input int thr);
        in_data = w; in_user = u; in_last = l; kernel_sel = ks; in_valid = 1'b1;
`ifdef SOBEL_THRESH_EN
        threshold = OW'(thr);
`endif
    endtask

    task automatic send(input logic [9*DW-1:0] w, input logic u, input logic l,
                        input logic [1:0] ks, input int thr);
        bit ok;
        ok = 1'b0;
        drive(w, u, l, ks, thr);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
        end
        chk("accept", ok, 1);
        if (ok) accept_push(w, u, l, ks, thr);
        @(posedge clk); #1;
        in_valid = 1'b0; in_user = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("sb_gx", out_gx, mon_e.gx);
                chk("sb_gy", out_gy, mon_e.gy);
                chk("sb_mag", out_mag, mon_e.mag);
                chk("sb_user", out_user, mon_e.user);
                chk("sb_last", out_last, mon_e.last);
`ifdef SOBEL_THRESH_EN
                chk("sb_edge", out_edge, mon_e.edg);
`endif
            end
        end
    end

    logic [9*DW-1:0] wsat, wb;
    logic [OW-1:0]   hold_gx, hold_mag;
    int              idx;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_user = 1'b0; in_last = 1'b0;
        kernel_sel = 2'd0; out_ready = 1'b1;
`ifdef SOBEL_THRESH_EN
        threshold = '1;
`endif
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_gx", out_gx, 0);
        chk("rst_gy", out_gy, 0);
        chk("rst_mag", out_mag, 0);
        chk("rst_user", out_user, 0);
        chk("rst_last", out_last, 0);
`ifdef SOBEL_THRESH_EN
        chk("rst_edge", out_edge, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sobel step edge, latency check
        send(cols(0, 0, 255), 1'b1, 1'b0, 2'd0, MAXV);
        chk("lat_0", out_valid, 0);
        @(posedge clk); #1; chk("lat_1", out_valid, 0);
        @(posedge clk); #1; chk("lat_2", out_valid, 1);
        chk("sobel_gx", out_gx, 1020);
        chk("sobel_gy", out_gy, 0);
        chk("sobel_mag", out_mag, 1020);
        chk("sobel_user", out_user, 1);
        drain();

        // Scharr on frame start; mid-frame Prewitt request ignored
        send(cols(0, 0, 255), 1'b1, 1'b0, 2'd2, MAXV);
        send(cols(0, 0, 255), 1'b0, 1'b0, 2'd1, MAXV);
        @(posedge clk); @(posedge clk); #1;
        chk("midframe_ksel_gx", out_gx, 4080);
        chk("midframe_ksel_mag", out_mag, 4080);
        drain();

        // Scharr saturation, user and last on one beat
        wsat = '0;
        wsat = setp(wsat, 0, 2, 255); wsat = setp(wsat, 1, 2, 255); wsat = setp(wsat, 2, 2, 255);
        wsat = setp(wsat, 2, 0, 255); wsat = setp(wsat, 2, 1, 255);
        send(wsat, 1'b1, 1'b1, 2'd2, MAXV);
        @(posedge clk); @(posedge clk); #1;
        chk("sat_gx", out_gx, 3315);
        chk("sat_gy", out_gy, 3315);
        chk("sat_mag", out_mag, 4095);
        chk("sat_user", out_user, 1);
        chk("sat_last", out_last, 1);
        drain();
        send(cols(9, 200, 3), 1'b0, 1'b0, 2'd0, MAXV);
        drain();

        // 20 back-to-back beats, downstream stall in cycles 5..9
        idx = 0;
        for (int cyc = 0; cyc < 200 && (idx < 20 || sb.size() != 0); cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            if (idx < 20) begin
                wb = setp(cols(0, 0, idx + 1), 2, 1, idx * 7);
                drive(wb, idx == 0, (idx % 5) == 4, 2'd0, MAXV);
            end else in_valid = 1'b0;
            @(negedge clk);
            if (cyc < 25) chk("stall_in_ready", in_ready, !(cyc >= 5 && cyc <= 9));
            if (cyc == 5) begin
                hold_gx = out_gx; hold_mag = out_mag;
            end else if (cyc > 5 && cyc <= 9) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_gx", out_gx, hold_gx);
                chk("hold_mag", out_mag, hold_mag);
            end
            if (in_valid && in_ready) begin
                accept_push(wb, idx == 0, (idx % 5) == 4, 2'd0, MAXV);
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_user = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        chk("stall_all_sent", idx, 20);
        drain();

        // Reset with three Scharr beats in flight
        send(cols(0, 0, 255), 1'b1, 1'b0, 2'd2, MAXV);
        send(cols(0, 0, 255), 1'b0, 1'b0, 2'd2, MAXV);
        send(cols(0, 0, 255), 1'b0, 1'b0, 2'd2, MAXV);
        rst_n = 1'b0;
        sb.delete();
        tb_mode = 0; tb_thr = MAXV;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_gx", out_gx, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_valid", out_valid, 0);
        send(cols(0, 0, 255), 1'b0, 1'b0, 2'd2, MAXV);
        @(posedge clk); @(posedge clk); #1;
        chk("postrst_sobel_gx", out_gx, 1020);
        drain();

`ifdef SOBEL_THRESH_EN
        send(cols(0, 0, 255), 1'b1, 1'b0, 2'd0, 500);
        send(cols(7, 7, 7), 1'b0, 1'b0, 2'd0, 4000);
        @(posedge clk); #1;
        chk("thr_edge_hi", out_edge, 1);
        @(posedge clk); #1;
        chk("thr_mag_flat", out_mag, 0);
        chk("thr_edge_lo", out_edge, 0);
        drain();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
